serial_adder_seq: RTL
=====================

# serial_adder_seq

Bit-serial adder sequencer. Latches two WIDTH-bit operands and a carry-in, then feeds one bit pair per clock, LSB first, into a single one-bit full-adder cell. The carry is kept in a flop between cycles, and the sum is collected in a shift register. The block is the upstream driver and downstream collector around the full-adder stage, and trades WIDTH cycles of latency for one adder cell of area.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 2..32
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request to begin an addition; accepted only when ready=1
- a_in  in  WIDTH  operand A, sampled on the accepting edge
- b_in  in  WIDTH  operand B, sampled on the accepting edge
- cin_in  in  1  carry-in, sampled on the accepting edge
- ready  out  1  high in IDLE and DONE; start is accepted only while high
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse; sum_out/cout_out are valid from this cycle
- sum_out  out  WIDTH  registered result; holds until the next completion
- cout_out  out  1  registered final carry-out
- ovf_out  out  1  signed overflow flag (see Configuration)

## Operation
- Reset (async, rst_n=0) forces:
  - state=IDLE, operand/sum shift registers=0, carry flop=0, bit counter=0
  - sum_out=0, cout_out=0, ovf_out=0, done=0
  - ready=1, busy=0
- States:
  - IDLE: wait for start.
  - RUN: one bit per cycle, for WIDTH cycles.
  - DONE: one cycle; outputs updated, done=1.
- IDLE, start=1: load A/B shift registers, carry flop←cin_in, counter←0, go to RUN.
- RUN, each edge:
  - full-adder cell inputs are a_sr[0], b_sr[0], carry flop
  - shift A/B right by one
  - shift the cell's sum bit into sum_sr at MSB
  - carry flop←cell cout
  - counter++
- RUN, edge where counter==WIDTH-1: the last bit is processed as above, and also:
  - sum_out←final sum_sr (LSB at bit 0), cout_out←cell cout
  - go to DONE
- DONE: done=1 for exactly one cycle.
  - If start=1, accept new operands, as in IDLE, and go to RUN (back-to-back; no idle bubble).
  - Otherwise go to IDLE.
- start while busy=1 is ignored; operands and progress are unaffected; no queueing.
- sum_out/cout_out/ovf_out change only on the RUN→DONE edge. They are stable during a following RUN.
- Arithmetic is unsigned modulo 2^WIDTH, with cout_out as bit WIDTH of a_in+b_in+cin_in.
- Counter width: $clog2(WIDTH). No wrap occurs because RUN always exits at WIDTH-1.

## Timing
- Start accepted at edge E0. Bits are processed at edges E1..EWIDTH. State is DONE after EWIDTH.
- Latency: done is high in the cycle following edge EWIDTH, i.e. WIDTH cycles after the accepting edge.
- Throughput: one result per WIDTH+1 cycles if start is held high; WIDTH+1 is the minimum accept-to-accept spacing.
- ready/busy are decoded combinationally from the registered state. done is a registered state decode.
- rst_n asserted mid-RUN: computation is abandoned immediately; all outputs take reset values, including sum_out=0. After release, the first accepting edge needs start=1.
- rst_n deassertion is assumed synchronised externally. The first active edge after release may accept start.

## Configuration
- SERIAL_ADD_OVF_EN defined:
  - ovf_out←(carry into MSB) XOR (carry out of MSB), registered with sum_out.
  - An extra flop captures the carry flop value before the final bit.
- SERIAL_ADD_OVF_EN undefined:
  - ovf_out is tied to 0 and the extra flop is removed.
  - The port stays present so the interface is identical.

## Structure
- Package serial_add_pkg: state enum (IDLE, RUN, DONE), default WIDTH constant, counter-width function.
- Sub-module: onebitfa, the existing one-bit full-adder cell, instantiated once as the combinational datapath. The sequencer holds all registers; the cell holds none.

## Test plan
- WIDTH=8, a=0x5A, b=0x33, cin=0, start pulse → done exactly 8 cycles after the accepting edge; sum_out=0x8D, cout_out=0.
- a=0xFF, b=0x01, cin=0 → sum_out=0x00, cout_out=1. Also a=0xFF, b=0x00, cin=1 → sum_out=0x00, cout_out=1.
- Start an addition; assert start again at RUN cycle 3 with a=0x11 → ignored; first result intact; ready=1 only after done.
- start held high continuously with a=0x01, b=0x01 then a=0x80, b=0x80 → done pulses 9 cycles apart; results 0x02/cout 0, then 0x00/cout 1.
- Assert rst_n=0 during RUN cycle 4 → sum_out=0, done=0, ready=1 immediately. Next start of 0x10+0x20 yields 0x30.
- a=0x7F, b=0x01, cin=0 → sum_out=0x80; ovf_out=1 with SERIAL_ADD_OVF_EN, 0 without. a=0x80, b=0x80 → ovf_out=1 with macro.

Source files
------------

// File: rtl/serial_add_pkg.sv
// Shared constants for the bit-serial adder: state encodings, default width,
// and the bit-counter width helper.
package serial_add_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;
  localparam int unsigned STATE_W       = 2;

  localparam logic [STATE_W-1:0] ST_IDLE = 2'd0;
  localparam logic [STATE_W-1:0] ST_RUN  = 2'd1;
  localparam logic [STATE_W-1:0] ST_DONE = 2'd2;

  // At least one bit, so a degenerate width still gets a legal vector.
  function automatic int unsigned cnt_width(input int unsigned width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/onebitfa.sv
// One-bit full-adder cell; purely combinational, holds no state.
module onebitfa (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder_seq.sv
// Bit-serial adder sequencer around a single onebitfa cell, LSB first.
// Optional signed-overflow flag enabled by defining SERIAL_ADD_OVF_EN.
module serial_adder_seq
  import serial_add_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin_in,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout_out,
  output logic             ovf_out
);

  localparam int unsigned CNT_W = cnt_width(WIDTH);

  logic [STATE_W-1:0] state;
  logic [STATE_W-1:0] state_nxt;
  logic               load_en;
  logic               shift_en;
  logic               last_bit;

  logic [WIDTH-1:0]   a_sr;
  logic [WIDTH-1:0]   b_sr;
  logic [WIDTH-1:0]   sum_sr;
  logic [WIDTH-1:0]   sum_nxt;
  logic               carry;
  logic [CNT_W-1:0]   cnt;
  logic               fa_s;
  logic               fa_co;

  onebitfa u_fa (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .cin  (carry),
    .s    (fa_s),
    .cout (fa_co)
  );

  assign last_bit = (cnt == CNT_W'(WIDTH - 1));
  assign sum_nxt  = {fa_s, sum_sr[WIDTH-1:1]};
  assign ready    = (state == ST_IDLE) || (state == ST_DONE);
  assign busy     = (state == ST_RUN);

  // Next-state and datapath control decode.
  always_comb begin
    state_nxt = state;
    load_en   = 1'b0;
    shift_en  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          load_en   = 1'b1;
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        shift_en = 1'b1;
        if (last_bit) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        if (start) begin
          load_en   = 1'b1;
          state_nxt = ST_RUN;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Operand/sum shifters, carry flop, bit counter and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr     <= '0;
      b_sr     <= '0;
      sum_sr   <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
      sum_out  <= '0;
      cout_out <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= shift_en && last_bit;
      if (load_en) begin
        a_sr  <= a_in;
        b_sr  <= b_in;
        carry <= cin_in;
        cnt   <= '0;
      end else if (shift_en) begin
        a_sr   <= a_sr >> 1;
        b_sr   <= b_sr >> 1;
        sum_sr <= sum_nxt;
        carry  <= fa_co;
        if (last_bit) begin
          cnt      <= '0;
          sum_out  <= sum_nxt;
          cout_out <= fa_co;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

`ifdef SERIAL_ADD_OVF_EN
  logic carry_msb;
  logic ovf_q;

  // carry_msb holds the carry into the MSB, taken as the next-to-last bit completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry_msb <= 1'b0;
      ovf_q     <= 1'b0;
    end else if (shift_en) begin
      if (cnt == CNT_W'(WIDTH - 2)) carry_msb <= fa_co;
      if (last_bit)                 ovf_q     <= carry_msb ^ fa_co;
    end
  end

  assign ovf_out = ovf_q;
`else
  assign ovf_out = 1'b0;
`endif

endmodule
